sram_port_arbiter: RTL

- Shares the single external 16-bit cellular SRAM between two requesters:
  - the CPU-side memory hierarchy (cache refill and writeback, port "c");
  - the VGA framebuffer fetcher (port "v").
- Grants one requester at a time and runs a fixed-timing asynchronous SRAM access.
- Returns read data with a one-cycle ready pulse.
- Sits inside the memory hierarchy, between the cache and VGA module and the top-level SRAM pins.

---
 rtl/sram_port_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter (CPU "c", VGA "v") in front of a 16-bit asynchronous SRAM.
// Optional macro SRAM_PORT_ARBITER_PMC_EN adds the pmc_conflict contention pulse output.
module sram_port_arbiter #(
    parameter int unsigned WAIT_CYCLES = 4,
    parameter int unsigned VGA_MAX_RUN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [1:0]  c_be,
    input  logic [22:0] c_addr,
    input  logic [15:0] c_wdata,
    output logic [15:0] c_rdata,
    output logic        c_rdy,
    input  logic        v_req,
    input  logic [22:0] v_addr,
    output logic [15:0] v_rdata,
    output logic        v_rdy,
    output logic        sram_ce,
    output logic        sram_oe,
    output logic        sram_we,
    output logic        sram_lb,
    output logic        sram_ub,
    output logic [22:0] sram_addr,
    inout  wire  [15:0] sram_data
`ifdef SRAM_PORT_ARBITER_PMC_EN
    ,
    output logic        pmc_conflict
`endif
);

    localparam int unsigned WaitEff  = (WAIT_CYCLES == 0) ? 1 :
                                       ((WAIT_CYCLES > 15) ? 15 : WAIT_CYCLES);
    localparam logic [3:0]  WaitLast = 4'(WaitEff - 1);
    localparam int unsigned RunW     = (VGA_MAX_RUN < 1) ? 1 : $clog2(VGA_MAX_RUN + 1);
    localparam logic [RunW-1:0] RunMax = RunW'(VGA_MAX_RUN);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;  // 1 = VGA owns the current transfer
    logic [22:0]       addr_q, addr_d;
    logic              we_q, we_d;
    logic [1:0]        be_q, be_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [3:0]        wait_q, wait_d;
    logic [RunW-1:0]   run_q, run_d;
    logic [15:0]       c_rdata_q, c_rdata_d;
    logic [15:0]       v_rdata_q, v_rdata_d;
    logic              grant_v;
    logic              active;

    // VGA wins contention until it has taken VGA_MAX_RUN grants in a row.
    assign grant_v = v_req & (~c_req | (run_q < RunMax));

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        we_d      = we_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        wait_d    = wait_q;
        run_d     = run_q;
        c_rdata_d = c_rdata_q;
        v_rdata_d = v_rdata_q;
        unique case (state_q)
            StIdle: begin
                if (c_req || v_req) begin
                    owner_d = grant_v;
                    addr_d  = grant_v ? v_addr : c_addr;
                    we_d    = ~grant_v & c_we;
                    be_d    = c_be;
                    wdata_d = c_wdata;
                    if (grant_v && c_req) begin
                        run_d = (run_q < RunMax) ? run_q + RunW'(1) : run_q;
                    end else begin
                        run_d = '0;
                    end
                    state_d = StSetup;
                end
            end
            StSetup: begin
                wait_d  = WaitLast;
                state_d = StAccess;
            end
            StAccess: begin
                if (wait_q == 4'd0) begin
                    if (!we_q) begin
                        if (owner_q) v_rdata_d = sram_data;
                        else         c_rdata_d = sram_data;
                    end
                    state_d = StDone;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            owner_q   <= 1'b0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            be_q      <= '0;
            wdata_q   <= '0;
            wait_q    <= '0;
            run_q     <= '0;
            c_rdata_q <= '0;
            v_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            wait_q    <= wait_d;
            run_q     <= run_d;
            c_rdata_q <= c_rdata_d;
            v_rdata_q <= v_rdata_d;
        end
    end

    // Controls decode from state so a reset deasserts them without waiting for a clock.
    assign active    = (state_q == StSetup) || (state_q == StAccess);
    assign sram_ce   = ~active;
    assign sram_oe   = ~(active & ~we_q);
    assign sram_we   = ~((state_q == StAccess) & we_q);
    assign sram_lb   = active ? (we_q & ~be_q[0]) : 1'b1;
    assign sram_ub   = active ? (we_q & ~be_q[1]) : 1'b1;
    assign sram_addr = addr_q;
    // Write data stays on the bus through DONE for hold time.
    assign sram_data = (we_q && state_q != StIdle) ? wdata_q : 16'hzzzz;

    assign c_rdata = c_rdata_q;
    assign v_rdata = v_rdata_q;
    assign c_rdy   = (state_q == StDone) & ~owner_q;
    assign v_rdy   = (state_q == StDone) & owner_q;

`ifdef SRAM_PORT_ARBITER_PMC_EN
    logic conflict_d;
    logic pmc_q;

    always_comb begin
        conflict_d = 1'b0;
        if (state_q == StIdle) begin
            if (c_req || v_req) conflict_d = grant_v ? c_req : v_req;
        end else begin
            conflict_d = owner_q ? c_req : v_req;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pmc_q <= 1'b0;
        else      pmc_q <= conflict_d;
    end

    assign pmc_conflict = pmc_q;
`endif

endmodule
